// File: rtl/shift_right_seq_pkg.sv
// Shared definitions for the sequential right shifter.
//   state_t           : FSM state encoding (IDLE, SHIFT, DONE)
//   FILL_LOGICAL/ARITH: fill-select values carried in the arith register
package shift_right_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    localparam logic FILL_LOGICAL = 1'b0;
    localparam logic FILL_ARITH   = 1'b1;

endpackage

// File: rtl/shift_right_seq_stage.sv
// sr_stage: one conditional right-shift stage (combinational).
// Ports:
//   data   : operand
//   stage  : stage index k; shift distance is 2^k
//   en     : 1 = shift this stage, 0 = pass data through
//   fill   : value shifted into the vacated MSBs
//   result : shifted (or passed-through) data
module sr_stage #(
    parameter int N = 32,
    parameter int S = $clog2(N)
) (
    input  logic [N-1:0] data,
    input  logic [S-1:0] stage,
    input  logic         en,
    input  logic         fill,
    output logic [N-1:0] result
);

    logic [S-1:0] amt;

    always_comb begin
        amt = S'(1) << stage;
        result = data;
        if (en) begin
            // A one-fill is a zero-fill of the inverted word, inverted back.
            if (fill) result = ~((~data) >> amt);
            else      result = data >> amt;
        end
    end

endmodule

// File: rtl/shift_right_seq.sv
// shift_right_seq: multi-cycle right shifter, one binary stage per cycle.
// A request is latched in IDLE, S = log2(N) stages are applied in SHIFT
// (stage k shifts by 2^k when shamt bit k is set), and the result is
// offered in DONE until consumed. Latency is always S cycles.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready/out_valid depend only on registered state, never on
// in_valid/out_ready.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid  : request valid          in_ready  : request can be accepted
//   in        : operand                shamt     : shift amount 0..N-1
//   arith     : 1 = sign fill, 0 = zero fill
//   out_valid : result valid           out_ready : consumer accepts result
//   out       : result (0 unless DONE)
//   dbg_state : current FSM state
module shift_right_seq
    import shift_right_seq_pkg::*;
#(
    parameter int N = 32,
    parameter int S = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in,
    input  logic [S-1:0] shamt,
    input  logic         arith,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output state_t       dbg_state
);

    state_t       state;
    logic [S-1:0] k;
    logic [N-1:0] data_reg;
    logic [S-1:0] shamt_reg;
    logic         arith_reg;
    logic [N-1:0] stage_out;
    logic         fill;

    // The MSB stays equal to the original sign bit in arithmetic mode, so
    // using the current MSB as fill is the same as using the original sign.
    assign fill = (arith_reg == FILL_ARITH) ? data_reg[N-1] : 1'b0;

    sr_stage #(.N(N), .S(S)) u_stage (
        .data   (data_reg),
        .stage  (k),
        .en     (shamt_reg[k]),
        .fill   (fill),
        .result (stage_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            k         <= '0;
            data_reg  <= '0;
            shamt_reg <= '0;
            arith_reg <= FILL_LOGICAL;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_reg  <= in;
                        shamt_reg <= shamt;
                        arith_reg <= arith;
                        k         <= '0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    data_reg <= stage_out;
                    k        <= k + S'(1);
                    if (k == S'(S - 1)) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign out       = (state == ST_DONE) ? data_reg : '0;
    assign dbg_state = state;

endmodule
